// File: rtl/game_ghost.sv
// Chaser sprite: follows the player's position along the maze rows/columns on
// move_clock, flags a catch, holds, then respawns at home. Draws a 16x16 box.
module game_ghost #(
    parameter int unsigned SPEED_DIV   = 2,
    parameter int unsigned START_DELAY = 256,
    parameter int unsigned HIT_DIST    = 12,
    parameter int unsigned HOLD_TICKS  = 512,
    parameter int unsigned HOME_H      = 640,
    parameter int unsigned HOME_V      = 480
) (
    input  logic        move_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [9:0]  location_left,
    input  logic [9:0]  location_top,
    input  logic        blank,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    output logic        r,
    output logic        g,
    output logic        b,
    output logic        caught,
    output logic [9:0]  ghost_left,
    output logic [9:0]  ghost_top
);

    localparam int unsigned TICK_W = 16;
    localparam int unsigned STEP_W = 16;
    localparam int unsigned POS_W  = 10;
    localparam int unsigned DIF_W  = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHASE  = 2'd1,
        ST_CAUGHT = 2'd2
    } state_t;

    state_t              r_state, w_state_nx;
    logic [POS_W-1:0]    r_gx, r_gy, w_gx_nx, w_gy_nx;
    logic [TICK_W-1:0]   r_tick, w_tick_nx;
    logic [STEP_W-1:0]   r_step, w_step_nx;
    logic                r_caught, w_caught_nx;

    logic [POS_W-1:0]    w_px, w_py, w_tx, w_ya, w_mv_x, w_mv_y;
    logic [DIF_W-1:0]    w_dx, w_dy, w_adx, w_ady, w_dt, w_dh;
    logic [DIF_W-1:0]    w_bx0, w_bx1, w_by0, w_by1;
    logic                w_hit, w_row_y, w_row_py, w_col_x, w_in_box;
    logic [2:0]          w_rgb;

    function automatic logic in_row(input logic [POS_W-1:0] y);
        return (y >= 10'd300 && y < 10'd315) ||
               (y >= 10'd475 && y < 10'd485) ||
               (y >= 10'd645 && y < 10'd660);
    endfunction

    function automatic logic in_col(input logic [POS_W-1:0] x);
        return (x >= 10'd375 && x < 10'd405) ||
               (x >= 10'd625 && x < 10'd655) ||
               (x >= 10'd875 && x < 10'd905);
    endfunction

    // Player position and 11-bit two's-complement distances (bit 10 = sign)
    assign w_px     = location_left + 10'd330;
    assign w_py     = location_top + 10'd265;
    assign w_dx     = {1'b0, r_gx} - {1'b0, w_px};
    assign w_dy     = {1'b0, r_gy} - {1'b0, w_py};
    assign w_adx    = w_dx[DIF_W-1] ? (~w_dx + 11'd1) : w_dx;
    assign w_ady    = w_dy[DIF_W-1] ? (~w_dy + 11'd1) : w_dy;
    assign w_hit    = (w_adx < DIF_W'(HIT_DIST)) && (w_ady < DIF_W'(HIT_DIST));
    assign w_row_y  = in_row(r_gy);
    assign w_row_py = in_row(w_py);
    assign w_col_x  = in_col(r_gx);
    assign w_tx     = ((r_gy == w_py) || !w_row_py) ? w_px : POS_W'(HOME_H);
    assign w_dt     = {1'b0, r_gx} - {1'b0, w_tx};
    assign w_dh     = {1'b0, r_gy} - DIF_W'(HOME_V);

    // One-pixel step choice; earlier rules take precedence
    always_comb begin
        w_mv_x = r_gx;
        w_mv_y = r_gy;
        w_ya   = r_gy;
        if (w_col_x && (w_dy != '0) && (w_row_py || (r_gx == w_px))) begin
            w_ya = w_dy[DIF_W-1] ? (r_gy + 10'd1) : (r_gy - 10'd1);
            if (w_ya < 10'd305)
                w_mv_y = 10'd305;
            else if (w_ya > 10'd655)
                w_mv_y = 10'd655;
            else
                w_mv_y = w_ya;
        end else if (w_row_y) begin
            if (w_dt != '0)
                w_mv_x = w_dt[DIF_W-1] ? (r_gx + 10'd1) : (r_gx - 10'd1);
        end else if (w_col_x) begin
            if (w_dh != '0)
                w_mv_y = w_dh[DIF_W-1] ? (r_gy + 10'd1) : (r_gy - 10'd1);
        end
    end

    always_ff @(posedge move_clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_gx     <= POS_W'(HOME_H);
            r_gy     <= POS_W'(HOME_V);
            r_tick   <= '0;
            r_step   <= '0;
            r_caught <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_gx     <= w_gx_nx;
            r_gy     <= w_gy_nx;
            r_tick   <= w_tick_nx;
            r_step   <= w_step_nx;
            r_caught <= w_caught_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_gx_nx     = r_gx;
        w_gy_nx     = r_gy;
        w_tick_nx   = r_tick;
        w_step_nx   = r_step;
        w_caught_nx = r_caught;
        if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_tick == TICK_W'(START_DELAY - 1)) begin
                        w_tick_nx  = '0;
                        w_state_nx = ST_CHASE;
                    end else begin
                        w_tick_nx = r_tick + TICK_W'(1);
                    end
                end
                ST_CHASE: begin
                    if (w_hit) begin
                        w_state_nx  = ST_CAUGHT;
                        w_tick_nx   = '0;
                        w_step_nx   = '0;
                        w_caught_nx = 1'b1;
                    end else if (r_step == STEP_W'(SPEED_DIV - 1)) begin
                        w_step_nx = '0;
                        w_gx_nx   = w_mv_x;
                        w_gy_nx   = w_mv_y;
                    end else begin
                        w_step_nx = r_step + STEP_W'(1);
                    end
                end
                ST_CAUGHT: begin
                    if (r_tick == TICK_W'(HOLD_TICKS - 1)) begin
                        w_state_nx  = ST_IDLE;
                        w_tick_nx   = '0;
                        w_gx_nx     = POS_W'(HOME_H);
                        w_gy_nx     = POS_W'(HOME_V);
                        w_caught_nx = 1'b0;
                    end else begin
                        w_tick_nx = r_tick + TICK_W'(1);
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    // Sprite box, combinational against the live raster position
    assign w_bx0    = {1'b0, r_gx} - 11'd330;
    assign w_bx1    = {1'b0, r_gx} - 11'd314;
    assign w_by0    = {1'b0, r_gy} - 11'd265;
    assign w_by1    = {1'b0, r_gy} - 11'd249;
    assign w_in_box = !blank && (hcount >= w_bx0) && (hcount < w_bx1) &&
                      (vcount >= w_by0) && (vcount < w_by1);

    always_comb begin
        w_rgb = 3'b000;
        if (w_in_box) begin
            case (r_state)
                ST_IDLE:   w_rgb = 3'b001;
                ST_CHASE:  w_rgb = 3'b101;
                ST_CAUGHT: w_rgb = {3{r_tick[4]}};
                default:   w_rgb = 3'b000;
            endcase
        end
    end

    assign r          = w_rgb[2];
    assign g          = w_rgb[1];
    assign b          = w_rgb[0];
    assign caught     = r_caught;
    assign ghost_left = r_gx - 10'd330;
    assign ghost_top  = r_gy - 10'd265;

endmodule

// File: tb/tb_game_ghost.sv
// Directed bench for game_ghost: stimulus pushes expected outputs into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_game_ghost;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [9:0]  location_left;
    logic [9:0]  location_top;
    logic        blank;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        r, g, b, caught;
    logic [9:0]  ghost_left, ghost_top;

    typedef struct {
        string      name;
        logic [9:0] left;
        logic [9:0] top;
        logic       cgt;
        logic [2:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    game_ghost #(
        .SPEED_DIV  (1),
        .START_DELAY(4),
        .HIT_DIST   (12),
        .HOLD_TICKS (8),
        .HOME_H     (640),
        .HOME_V     (480)
    ) dut (
        .move_clock   (clk),
        .reset        (reset),
        .enable       (enable),
        .location_left(location_left),
        .location_top (location_top),
        .blank        (blank),
        .hcount       (hcount),
        .vcount       (vcount),
        .r            (r),
        .g            (g),
        .b            (b),
        .caught       (caught),
        .ghost_left   (ghost_left),
        .ghost_top    (ghost_top)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input string fld, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
        end
    endfunction

    // Monitor: compare every pending expectation against the live outputs
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.name, "left",   int'(ghost_left), int'(e.left));
            check(e.name, "top",    int'(ghost_top),  int'(e.top));
            check(e.name, "caught", int'(caught),     int'(e.cgt));
            check(e.name, "rgb",    int'({r, g, b}),  int'(e.rgb));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input string nm, input int left, input int top, input bit cg,
                          input int h, input int v, input bit bl, input bit [2:0] rgb);
        exp_t e;
        hcount = 11'(h);
        vcount = 11'(v);
        blank  = bl;
        e.name = nm;
        e.left = 10'(left);
        e.top  = 10'(top);
        e.cgt  = cg;
        e.rgb  = rgb;
        sb.push_back(e);
    endtask

    task automatic exp_in(input string nm, input int left, input int top, input bit cg,
                          input bit [2:0] rgb);
        exp_at(nm, left, top, cg, left + 5, top + 5, 1'b0, rgb);
    endtask

    task automatic player(input int l, input int t);
        location_left = 10'(l);
        location_top  = 10'(t);
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        blank  = 1'b0;
        hcount = '0;
        vcount = '0;
        player(470, 215);

        // Reset state and display box edges
        tick(1);
        exp_in("rst_home", 310, 215, 1'b0, 3'b001);
        tick(1);
        exp_at("rst_blank", 310, 215, 1'b0, 315, 220, 1'b1, 3'b000);
        tick(1);
        exp_at("rst_right_edge", 310, 215, 1'b0, 326, 220, 1'b0, 3'b000);
        tick(1);
        exp_at("rst_bottom_edge", 310, 215, 1'b0, 320, 231, 1'b0, 3'b000);
        reset = 1'b1;

        // Player at (800,480): chase along the middle row
        tick(3);
        exp_in("idle_3", 310, 215, 1'b0, 3'b001);
        tick(1);
        exp_in("chase_entry", 310, 215, 1'b0, 3'b101);
        tick(1);
        exp_in("first_step", 311, 215, 1'b0, 3'b101);
        tick(148);
        exp_in("row_789", 459, 215, 1'b0, 3'b101);
        tick(1);
        exp_in("row_caught", 459, 215, 1'b1, 3'b000);
        enable = 1'b0;
        tick(5);
        exp_in("caught_frozen", 459, 215, 1'b1, 3'b000);
        enable = 1'b1;
        tick(7);
        exp_in("hold_last", 459, 215, 1'b1, 3'b000);
        tick(1);
        exp_in("respawn1", 310, 215, 1'b0, 3'b001);

        // Player at (640,655): rule a downward, IDLE freeze
        player(310, 390);
        tick(2);
        enable = 1'b0;
        tick(5);
        enable = 1'b1;
        tick(1);
        exp_in("idle_frozen", 310, 215, 1'b0, 3'b001);
        tick(1);
        exp_in("chase2_entry", 310, 215, 1'b0, 3'b101);
        tick(164);
        exp_in("col_644", 310, 379, 1'b0, 3'b101);
        tick(1);
        exp_in("col_caught", 310, 379, 1'b1, 3'b000);
        tick(8);
        exp_in("respawn2", 310, 215, 1'b0, 3'b001);

        // Player at (500,305): up the column, then left along the top row
        player(170, 40);
        tick(4);
        exp_in("chase3_entry", 310, 215, 1'b0, 3'b101);
        tick(175);
        exp_in("top_row_305", 310, 40, 1'b0, 3'b101);
        tick(1);
        exp_in("turn_left", 309, 40, 1'b0, 3'b101);
        enable = 1'b0;
        tick(5);
        exp_in("chase_frozen", 309, 40, 1'b0, 3'b101);
        enable = 1'b1;
        tick(128);
        exp_in("left_511", 181, 40, 1'b0, 3'b101);
        tick(1);
        exp_in("left_caught", 181, 40, 1'b1, 3'b000);
        tick(8);
        exp_in("respawn3", 310, 215, 1'b0, 3'b001);

        // Steer ghost to (640,400), then chase player at (890,550)
        player(310, 35);
        tick(4);
        tick(80);
        exp_in("at_640_400", 310, 135, 1'b0, 3'b101);
        player(560, 285);
        tick(74);
        exp_in("rule_c_474", 310, 209, 1'b0, 3'b101);
        tick(1);
        exp_in("rule_c_475", 310, 210, 1'b0, 3'b101);
        tick(250);
        exp_in("rule_b_890", 560, 210, 1'b0, 3'b101);
        tick(64);
        exp_in("rule_a_539", 560, 274, 1'b0, 3'b101);
        tick(1);
        exp_in("far_caught", 560, 274, 1'b1, 3'b000);
        tick(8);
        exp_in("respawn4", 310, 215, 1'b0, 3'b001);

        // Asynchronous reset in the middle of a chase
        player(470, 215);
        tick(4);
        tick(10);
        exp_in("pre_async", 320, 215, 1'b0, 3'b101);
        tick(1);
        #1;
        reset = 1'b0;
        exp_in("async_rst", 310, 215, 1'b0, 3'b001);
        tick(1);
        reset = 1'b1;

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
